m_code_sliding_correlator: RTL and testbench

//   Downstream acquisition stage for the G2 M-code generator. Each chip it correlates the

---
 rtl/m_code_sliding_correlator.sv | 157 +++++++++++++++
 tb/tb_m_code_sliding_correlator.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_code_sliding_correlator.sv
// Sliding correlator for G2 M-code acquisition: integrates chip matches per window,
// slips the local generator one chip on a failed search window, and tracks lock.
module m_code_sliding_correlator #(
    parameter int CHIP_CLKS   = 3052,
    parameter int SAMPLE_PT   = 1526,
    parameter int INT_CHIPS   = 256,
    parameter int ACC_W       = 9,
    parameter int THRESH      = 224,
    parameter int LOSS_THRESH = 160,
    parameter int MISS_MAX    = 3,
    parameter int MAX_SLIPS   = 2047
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             m_code,
    input  logic             rx_chip,
    output logic             shift_parse,
    output logic             locked,
    output logic             search_fail,
    output logic             dump_valid,
    output logic [ACC_W-1:0] corr_out,
    output logic [11:0]      slip_cnt
);

    localparam int CNT_W  = $clog2(CHIP_CLKS);
    localparam int IDX_W  = $clog2(INT_CHIPS);
    localparam int MISS_W = $clog2(MISS_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CHIP_CLKS - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_AT = CNT_W'(SAMPLE_PT);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(INT_CHIPS - 1);
    localparam logic [ACC_W-1:0]  LOCK_TH   = ACC_W'(THRESH);
    localparam logic [ACC_W-1:0]  LOSS_TH   = ACC_W'(LOSS_THRESH);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);
    localparam logic [11:0]       SLIP_LAST = 12'(MAX_SLIPS - 1);

    typedef enum logic [1:0] {IDLE, SEARCH, SLIP, LOCK} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  chip_cnt;
    logic [IDX_W-1:0]  chip_idx;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  corr_now;
    logic [MISS_W-1:0] miss_cnt;
    logic              slip_req;
    logic              match;
    logic              sample;
    logic              dump;
    logic              miss;

    assign match    = m_code ~^ rx_chip;
    assign sample   = ((state == SEARCH) || (state == LOCK)) && (chip_cnt == SAMPLE_AT);
    assign dump     = sample && (chip_idx == IDX_LAST);
    assign corr_now = acc + {{(ACC_W-1){1'b0}}, match};
    assign miss     = corr_now < LOSS_TH;

    assign shift_parse = (state == SLIP);
    assign locked      = (state == LOCK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A failed search window slips one cycle after its dump strobe; a lost lock does not slip.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = SEARCH;
                SEARCH: begin
                    if (dump && (corr_now >= LOCK_TH)) state_nxt = LOCK;
                    else if (slip_req)                 state_nxt = SLIP;
                end
                SLIP:    state_nxt = SEARCH;
                LOCK:    if (dump && miss && (miss_cnt == MISS_LAST)) state_nxt = SEARCH;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chip_cnt    <= '0;
            chip_idx    <= '0;
            acc         <= '0;
            miss_cnt    <= '0;
            slip_req    <= 1'b0;
            dump_valid  <= 1'b0;
            corr_out    <= '0;
            slip_cnt    <= '0;
            search_fail <= 1'b0;
        end else begin
            dump_valid <= 1'b0;
            slip_req   <= 1'b0;
            if (abort) begin
                chip_cnt <= '0;
                chip_idx <= '0;
                acc      <= '0;
                miss_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        chip_cnt <= '0;
                        if (start) begin
                            chip_idx    <= '0;
                            acc         <= '0;
                            miss_cnt    <= '0;
                            slip_cnt    <= '0;
                            search_fail <= 1'b0;
                        end
                    end
                    SLIP: begin
                        // Realign with the generator, which clears its chip counter on shift_parse
                        chip_cnt <= '0;
                        chip_idx <= '0;
                        acc      <= '0;
                        if (slip_cnt == SLIP_LAST) begin
                            slip_cnt    <= '0;
                            search_fail <= 1'b1;
                        end else begin
                            slip_cnt <= slip_cnt + 12'd1;
                        end
                    end
                    default: begin
                        chip_cnt <= (chip_cnt == CNT_LAST) ? '0 : chip_cnt + CNT_W'(1);
                        if (dump) begin
                            corr_out   <= corr_now;
                            dump_valid <= 1'b1;
                            acc        <= '0;
                            chip_idx   <= '0;
                            if (state == SEARCH) begin
                                if (corr_now >= LOCK_TH) miss_cnt <= '0;
                                else                     slip_req <= 1'b1;
                            end else if (!miss || (miss_cnt == MISS_LAST)) begin
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + MISS_W'(1);
                            end
                        end else if (sample) begin
                            acc      <= corr_now;
                            chip_idx <= chip_idx + IDX_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_m_code_sliding_correlator.sv
// Bench for m_code_sliding_correlator: window-level model plus directed acquisition scenarios.
module tb_m_code_sliding_correlator;

    localparam int CHIP_CLKS   = 8;
    localparam int SAMPLE_PT   = 4;
    localparam int INT_CHIPS   = 16;
    localparam int ACC_W       = 5;
    localparam int THRESH      = 14;
    localparam int LOSS_THRESH = 10;
    localparam int MISS_MAX    = 2;
    localparam int MAX_SLIPS   = 7;

    localparam int M_IDLE = 0, M_SEARCH = 1, M_SLIP = 2, M_LOCK = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             m_code = 1'b0;
    logic             rx_chip = 1'b0;
    logic             shift_parse;
    logic             locked;
    logic             search_fail;
    logic             dump_valid;
    logic [ACC_W-1:0] corr_out;
    logic [11:0]      slip_cnt;

    int tests = 0;
    int fails = 0;

    m_code_sliding_correlator #(
        .CHIP_CLKS(CHIP_CLKS), .SAMPLE_PT(SAMPLE_PT), .INT_CHIPS(INT_CHIPS), .ACC_W(ACC_W),
        .THRESH(THRESH), .LOSS_THRESH(LOSS_THRESH), .MISS_MAX(MISS_MAX), .MAX_SLIPS(MAX_SLIPS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .m_code(m_code), .rx_chip(rx_chip),
        .shift_parse(shift_parse), .locked(locked), .search_fail(search_fail),
        .dump_valid(dump_valid), .corr_out(corr_out), .slip_cnt(slip_cnt)
    );

    always #5 clk = ~clk;

    // Window-level model: per-chip match bits are queued and summed at the end of a window.
    int mm, mphase, mcorr, mslips, mmiss, msum, mprev;
    bit mdv, msfail, mdue, mdue_now;
    bit mwin[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mm = M_IDLE; mphase = 0; mwin.delete(); mcorr = 0; mdv = 0;
            mslips = 0; msfail = 0; mmiss = 0; mdue = 0;
        end else begin
            mdue_now = mdue; mdue = 0; mdv = 0;
            mprev = mm;
            if (abort) begin
                mm = M_IDLE; mphase = 0; mwin.delete(); mmiss = 0;
            end else if (mm == M_IDLE) begin
                if (start) begin
                    mm = M_SEARCH; mphase = 0; mwin.delete();
                    mslips = 0; msfail = 0; mmiss = 0;
                end
            end else if (mm == M_SLIP) begin
                mslips = mslips + 1;
                if (mslips == MAX_SLIPS) begin mslips = 0; msfail = 1; end
                mphase = 0; mwin.delete(); mm = M_SEARCH;
            end else begin
                if (mphase == SAMPLE_PT) begin
                    mwin.push_back(~(m_code ^ rx_chip));
                    if (mwin.size() == INT_CHIPS) begin
                        msum = 0;
                        foreach (mwin[i]) msum += int'(mwin[i]);
                        mwin.delete();
                        mcorr = msum; mdv = 1;
                        if (mprev == M_SEARCH) begin
                            if (msum >= THRESH) begin mm = M_LOCK; mmiss = 0; end
                            else mdue = 1;
                        end else if (msum < LOSS_THRESH) begin
                            mmiss = mmiss + 1;
                            if (mmiss == MISS_MAX) begin mm = M_SEARCH; mmiss = 0; end
                        end else begin
                            mmiss = 0;
                        end
                    end
                end
                mphase = (mphase + 1) % CHIP_CLKS;
                if (mprev == M_SEARCH && mdue_now) mm = M_SLIP;
            end
        end
    end

    // Stimulus: pat 0 = first `target` chips of each window match; pat 1 = random with
    // 3 forced mismatches; pat 2 = 8 matches until 3 slips, then full match.
    int  pat = 0;
    int  target = 16;
    int  dk;
    bit  dbit;

    always @(negedge clk) begin
        dk = mwin.size();
        case (pat)
            0:       dbit = (dk < target);
            1:       dbit = (dk < 3) ? 1'b0 : 1'($urandom_range(0, 1));
            default: dbit = (dk < ((mslips < 3) ? 8 : 16));
        endcase
        rx_chip = 1'($urandom_range(0, 1));
        m_code  = ~(rx_chip ^ dbit);
    end

    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if (shift_parse !== (mm == M_SLIP) || locked !== (mm == M_LOCK) ||
                dump_valid !== mdv || corr_out !== ACC_W'(mcorr) ||
                slip_cnt !== 12'(mslips) || search_fail !== msfail) begin
                fails++;
                if (fails < 20)
                    $display("FAIL model_cmp t=%0t got sp=%b lk=%b sf=%b dv=%b corr=%0d slip=%0d want sp=%b lk=%b sf=%b dv=%b corr=%0d slip=%0d",
                             $time, shift_parse, locked, search_fail, dump_valid, corr_out, slip_cnt,
                             mm == M_SLIP, mm == M_LOCK, msfail, mdv, mcorr, mslips);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
    endtask

    task automatic wait_dv(input string name, input int budget);
        bit got;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (dump_valid) got = 1;
        end
        if (!got) chk({name, "_dv_timeout"}, 0, 1);
    endtask

    task automatic wait_slip(input string name, input int budget);
        bit got;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (shift_parse) got = 1;
        end
        if (!got) chk({name, "_slip_timeout"}, 0, 1);
    endtask

    int  pulses, pcorr, pslip, dvs;
    bit  pdv, got;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_locked", locked, 0);
        chk("rst_shift", shift_parse, 0);
        chk("rst_dv", dump_valid, 0);
        chk("rst_corr", corr_out, 0);
        chk("rst_slip", slip_cnt, 0);
        chk("rst_sfail", search_fail, 0);
        #2 rst = 1'b0;

        // 1: aligned code locks on the first window
        pat = 0; target = 16;
        pulse_start();
        wait_dv("t1", 300);
        chk("t1_corr", corr_out, 16);
        chk("t1_locked", locked, 1);
        chk("t1_shift", shift_parse, 0);
        chk("t1_slip", slip_cnt, 0);

        // 2: code offset by 3 chips needs three slips
        pulse_abort();
        pat = 2;
        pulse_start();
        pulses = 0; pdv = 0; pcorr = 0; got = 0;
        for (int i = 0; i < 1500 && !got; i++) begin
            @(negedge clk);
            if (shift_parse) begin
                pulses++;
                chk("t2_slip_after_fail_dump", int'(pdv && pcorr < THRESH), 1);
            end
            if (dump_valid && locked) got = 1;
            pdv = dump_valid; pcorr = int'(corr_out);
        end
        chk("t2_locked", int'(got), 1);
        chk("t2_pulses", pulses, 3);
        chk("t2_slip_cnt", slip_cnt, 3);
        chk("t2_corr", corr_out, 16);

        // 3: uncorrelated input wraps the slip counter and sets search_fail
        pulse_abort();
        pat = 1;
        pulse_start();
        got = 0; pslip = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (search_fail) got = 1;
            else pslip = int'(slip_cnt);
        end
        chk("t3_sfail_set", int'(got), 1);
        chk("t3_slip_before_wrap", pslip, 6);
        chk("t3_slip_wrapped", slip_cnt, 0);
        wait_slip("t3_continue", 400);
        @(negedge clk);
        chk("t3_slip_after_wrap", slip_cnt, 1);
        chk("t3_sfail_sticky", search_fail, 1);
        pulse_abort();
        chk("t3_sfail_after_abort", search_fail, 1);
        pulse_start();
        chk("t3_sfail_cleared", search_fail, 0);
        chk("t3_slip_cleared", slip_cnt, 0);

        // 4: lock tracking with misses
        pulse_abort();
        pat = 0; target = 16;
        pulse_start();
        wait_dv("t4_lock", 300);
        chk("t4_locked", locked, 1);
        target = 9;  wait_dv("t4_w1", 300);
        chk("t4_w1_corr", corr_out, 9);  chk("t4_w1_locked", locked, 1);
        target = 10; wait_dv("t4_w2", 300);
        chk("t4_w2_corr", corr_out, 10); chk("t4_w2_locked", locked, 1);
        target = 9;  wait_dv("t4_w3", 300);
        chk("t4_w3_locked", locked, 1);
        wait_dv("t4_w4", 300);
        chk("t4_w4_corr", corr_out, 9);  chk("t4_w4_locked", locked, 0);
        @(negedge clk);
        chk("t4_no_slip_on_loss", shift_parse, 0);

        // 5: exact lock threshold
        pulse_abort();
        target = 14;
        pulse_start();
        wait_dv("t5_14", 300);
        chk("t5_corr14", corr_out, 14);
        chk("t5_lock14", locked, 1);
        pulse_abort();
        target = 13;
        pulse_start();
        wait_dv("t5_13", 300);
        chk("t5_corr13", corr_out, 13);
        chk("t5_lock13", locked, 0);
        @(negedge clk);
        chk("t5_shift13", shift_parse, 1);
        @(negedge clk);
        chk("t5_slip13", slip_cnt, 1);

        // 6: abort mid-window, start ignored while searching, start+abort together
        pulse_abort();
        target = 16;
        pulse_start();
        repeat (30) @(negedge clk);
        pulse_start();
        chk("t6_start_ignored_locked", locked, 0);
        repeat (20) @(negedge clk);
        pulse_abort();
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        dvs = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dump_valid || shift_parse) dvs++;
        end
        chk("t6_no_dump_after_abort", dvs, 0);

        // async reset in the middle of a SLIP cycle
        target = 13;
        pulse_start();
        wait_slip("t6_slip", 300);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_shift", shift_parse, 0);
        chk("t6_rst_locked", locked, 0);
        chk("t6_rst_corr", corr_out, 0);
        chk("t6_rst_slip", slip_cnt, 0);
        chk("t6_rst_dv", dump_valid, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_idle_after_rst", locked, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
